// File: rtl/rom_stream_reader.sv
// Streams a burst of consecutive ROM words out over a valid/ready interface.
// Reads are credit-limited so the return FIFO can never overflow.
//
// state   | meaning
// --------+--------------------------------------------------------------
// S_IDLE  | waiting for start; count=0 requests only pulse done
// S_ISSUE | presenting addresses to the ROM while FIFO credit allows
// S_DRAIN | all addresses issued; waiting for the last beat to transfer
module rom_stream_reader #(
   parameter int ADDR_W  = 3,
   parameter int DATA_W  = 8,
   parameter int ROM_LAT = 1
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              start_i,
   input  logic [ADDR_W-1:0] base_i,
   input  logic [ADDR_W:0]   count_i,
   output logic [ADDR_W-1:0] rom_addr_o,
   input  logic [DATA_W-1:0] rom_data_i,
   output logic              out_valid_o,
   input  logic              out_ready_i,
   output logic [DATA_W-1:0] out_data_o,
   output logic              out_last_o,
   output logic              busy_o,
   output logic              done_o
);
   localparam int DEPTH = ROM_LAT + 2;
   localparam int CNT_W = $clog2(DEPTH + 1);
   localparam int PTR_W = $clog2(DEPTH);
   localparam logic [ADDR_W:0]  MAX_WORDS = {1'b1, {ADDR_W{1'b0}}};
   localparam logic [PTR_W-1:0] PTR_LAST  = PTR_W'(DEPTH - 1);

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN} state_t;

   state_t            state_q;
   logic [ADDR_W-1:0] rom_addr_q;
   logic [ADDR_W:0]   left_q;
   logic              busy_q;
   logic              done_q;

   logic [DATA_W-1:0] fifo_data_q [DEPTH];
   logic              fifo_last_q [DEPTH];
   logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]  fcnt_q, fcnt_d;

   logic [CNT_W-1:0]  inflight;
   logic              issue_fire, issue_last;
   logic              ret_valid, ret_last;
   logic              push, pop, beat_last;

   // Reads in flight plus buffered words never exceed the FIFO depth.
   assign issue_fire = (state_q == S_ISSUE) &&
                       (((CNT_W+1)'(inflight) + (CNT_W+1)'(fcnt_q)) < (CNT_W+1)'(DEPTH));
   assign issue_last = issue_fire && (left_q == (ADDR_W+1)'(1));

   if (ROM_LAT == 0) begin : g_lat0
      assign ret_valid = issue_fire;
      assign ret_last  = issue_last;
      assign inflight  = '0;
   end else begin : g_lat
      logic [ROM_LAT-1:0] vld_q;
      logic [ROM_LAT-1:0] lst_q;

      always_ff @(posedge clk_i or posedge rst_i) begin
         if (rst_i) begin
            vld_q <= '0;
            lst_q <= '0;
         end else begin
            vld_q[0] <= issue_fire;
            lst_q[0] <= issue_last;
            for (int i = 1; i < ROM_LAT; i++) begin
               vld_q[i] <= vld_q[i-1];
               lst_q[i] <= lst_q[i-1];
            end
         end
      end

      assign ret_valid = vld_q[ROM_LAT-1];
      assign ret_last  = lst_q[ROM_LAT-1];

      always_comb begin
         inflight = '0;
         for (int i = 0; i < ROM_LAT; i++) begin
            inflight = inflight + CNT_W'(vld_q[i]);
         end
      end
   end

   assign push      = ret_valid;
   assign pop       = out_valid_o && out_ready_i;
   assign beat_last = pop && out_last_o;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (push) begin
         wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
         rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + PTR_W'(1);
      end
      fcnt_d = fcnt_q + CNT_W'(push) - CNT_W'(pop);
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         fcnt_q   <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            fifo_data_q[i] <= '0;
            fifo_last_q[i] <= 1'b0;
         end
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         fcnt_q   <= fcnt_d;
         if (push) begin
            fifo_data_q[wr_ptr_q] <= rom_data_i;
            fifo_last_q[wr_ptr_q] <= ret_last;
         end
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q    <= S_IDLE;
         rom_addr_q <= '0;
         left_q     <= '0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (start_i) begin
                  if (count_i == '0) begin
                     done_q <= 1'b1;
                  end else begin
                     state_q    <= S_ISSUE;
                     rom_addr_q <= base_i;
                     left_q     <= (count_i > MAX_WORDS) ? MAX_WORDS : count_i;
                     busy_q     <= 1'b1;
                  end
               end
            end
            S_ISSUE: begin
               if (issue_fire) begin
                  rom_addr_q <= rom_addr_q + ADDR_W'(1);
                  left_q     <= left_q - (ADDR_W+1)'(1);
                  if (issue_last) begin
                     state_q <= S_DRAIN;
                  end
               end
            end
            S_DRAIN: begin
               if (beat_last) begin
                  state_q <= S_IDLE;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign rom_addr_o  = rom_addr_q;
   assign out_valid_o = (fcnt_q != '0);
   assign out_data_o  = fifo_data_q[rd_ptr_q];
   assign out_last_o  = fifo_last_q[rd_ptr_q];
   assign busy_o      = busy_q;
   assign done_o      = done_q;
endmodule
